// File: rtl/game_pkg.sv
// Shared types and defaults for the Stop-It game controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    STARTING     = 3'd1,
    DECREMENTING = 3'd2,
    CORRECT      = 3'd3,
    WRONG        = 3'd4,
    WON          = 3'd5
  } game_state_e;

  localparam int unsigned START_DELAY_DEF = 8;
  localparam int unsigned RESULT_HOLD_DEF = 8;
  localparam int unsigned WIN_SCORE_DEF   = 9;

  // Width for a timer that must hold max(a,b)-1; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Button, counter and display signals between the game controller and its neighbours.
interface game_controller_if;
  logic       start_i;
  logic       stop_i;
  logic [4:0] random_i;
  logic [4:0] count_i;
  logic       counter_en_o;
  logic [4:0] target_o;
  logic [3:0] score_o;
  logic [2:0] state_o;
  logic       flash_o;
  logic       won_o;

  modport master (
    output start_i, stop_i, random_i, count_i,
    input  counter_en_o, target_o, score_o, state_o, flash_o, won_o
  );

  modport slave (
    input  start_i, stop_i, random_i, count_i,
    output counter_en_o, target_o, score_o, state_o, flash_o, won_o
  );
endinterface

// File: rtl/game_hold_timer.sv
// Loadable saturating down-counter shared by the start delay and the result hold.
module game_hold_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_4_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load_i) begin
      count <= load_value_i;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done_o = (count == '0);

endmodule

// File: rtl/game_controller.sv
// Stop-It round sequencer: runs the counter, judges the stop press, keeps score.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned START_DELAY = START_DELAY_DEF,
  parameter int unsigned RESULT_HOLD = RESULT_HOLD_DEF,
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF
) (
  input logic              clk_4_i,
  input logic              rst_i,
  game_controller_if.slave bus
);

  localparam int unsigned     TW          = timer_width(START_DELAY, RESULT_HOLD);
  localparam logic [TW-1:0]   START_LOAD  = TW'(START_DELAY - 1);
  localparam logic [TW-1:0]   RESULT_LOAD = TW'(RESULT_HOLD - 1);
  localparam logic [3:0]      WIN         = 4'(WIN_SCORE);

  game_state_e   state, state_next;
  logic [4:0]    target, target_next;
  logic [3:0]    score, score_next;
  logic          flash, flash_next;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_done;

  game_hold_timer #(.WIDTH(TW)) u_timer (
    .clk_4_i      (clk_4_i),
    .rst_i        (rst_i),
    .load_i       (timer_load),
    .load_value_i (timer_value),
    .done_o       (timer_done)
  );

  always_comb begin
    state_next  = state;
    target_next = target;
    score_next  = score;
    timer_load  = 1'b0;
    timer_value = START_LOAD;
    unique case (state)
      IDLE, WON: begin
        if (bus.start_i) begin
          state_next  = STARTING;
          target_next = bus.random_i;
          score_next  = '0;
          timer_load  = 1'b1;
        end
      end
      STARTING: begin
        if (timer_done) state_next = DECREMENTING;
      end
      DECREMENTING: begin
        // A stop on the zero count is still judged as a stop, not a timeout.
        if (bus.stop_i) begin
          timer_load  = 1'b1;
          timer_value = RESULT_LOAD;
          if (bus.count_i == target) begin
            state_next = CORRECT;
            score_next = score + 4'd1;
          end else begin
            state_next = WRONG;
          end
        end else if (bus.count_i == '0) begin
          state_next  = WRONG;
          timer_load  = 1'b1;
          timer_value = RESULT_LOAD;
        end
      end
      CORRECT: begin
        if (timer_done) begin
          if (score == WIN) begin
            state_next = WON;
          end else begin
            state_next  = STARTING;
            target_next = bus.random_i;
            timer_load  = 1'b1;
          end
        end
      end
      WRONG: begin
        if (timer_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Flash restarts at 0 on entering a result state and toggles while staying there.
    if (state_next inside {CORRECT, WRONG, WON} && state_next == state)
      flash_next = ~flash;
    else
      flash_next = 1'b0;
  end

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      target <= '0;
      score  <= '0;
      flash  <= 1'b0;
    end else begin
      state  <= state_next;
      target <= target_next;
      score  <= score_next;
      flash  <= flash_next;
    end
  end

  assign bus.state_o      = state;
  assign bus.counter_en_o = (state == DECREMENTING);
  assign bus.won_o        = (state == WON);
  assign bus.target_o     = target;
  assign bus.score_o      = score;
  assign bus.flash_o      = flash;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: cycle model of the game rules plus directed and random play.
module tb_game_controller;

  localparam int SD = 8;
  localparam int RH = 8;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_controller_if gif();

  game_controller #(
    .START_DELAY (SD),
    .RESULT_HOLD (RH),
    .WIN_SCORE   (WS)
  ) dut (
    .clk_4_i (clk),
    .rst_i   (rst),
    .bus     (gif)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Environment stand-in for game_counter: reloads 31 while disabled, counts down when enabled.
  always @(posedge clk or posedge rst) begin
    if (rst) gif.count_i <= 5'h1F;
    else     gif.count_i <= gif.counter_en_o ? gif.count_i - 5'd1 : 5'h1F;
  end

  // Game rules model: phase number plus cycles left in the current timed phase.
  int m_state, m_left, m_target, m_score;
  bit m_flash;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_left = 0; m_target = 0; m_score = 0; m_flash = 0;
    end else begin
      int ns;
      ns = m_state;
      case (m_state)
        0, 5: if (gif.start_i) begin
          ns = 1; m_left = SD; m_target = int'(gif.random_i); m_score = 0;
        end
        1: if (m_left <= 1) ns = 2; else m_left--;
        2: begin
          if (gif.stop_i) begin
            if (int'(gif.count_i) == m_target) begin ns = 3; m_score++; end
            else ns = 4;
            m_left = RH;
          end else if (gif.count_i == 5'd0) begin
            ns = 4; m_left = RH;
          end
        end
        3: if (m_left <= 1) begin
          if (m_score == WS) ns = 5;
          else begin ns = 1; m_left = SD; m_target = int'(gif.random_i); end
        end else m_left--;
        4: if (m_left <= 1) ns = 0; else m_left--;
        default: ns = 0;
      endcase
      m_flash = (ns >= 3 && ns == m_state) ? !m_flash : 1'b0;
      m_state = ns;
    end
  end

  always @(negedge clk) begin
    check("state",  int'(gif.state_o), m_state);
    check("en",     int'(gif.counter_en_o), (m_state == 2) ? 1 : 0);
    check("won",    int'(gif.won_o), (m_state == 5) ? 1 : 0);
    check("target", int'(gif.target_o), m_target);
    check("score",  int'(gif.score_o), m_score);
    check("flash",  int'(gif.flash_o), int'(m_flash));
  end

  // Called just after a falling edge; holds the inputs for one full cycle.
  task automatic step(input bit s, input bit p, input logic [4:0] r);
    gif.start_i  = s;
    gif.stop_i   = p;
    gif.random_i = r;
    @(negedge clk);
    gif.start_i = 1'b0;
    gif.stop_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'($urandom));
  endtask

  initial begin
    int n;
    gif.start_i  = 1'b0;
    gif.stop_i   = 1'b0;
    gif.random_i = 5'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", int'(gif.state_o), 0);
    check("rst_target", int'(gif.target_o), 0);
    check("rst_score", int'(gif.score_o), 0);
    check("rst_en", int'(gif.counter_en_o), 0);
    rst = 1'b0;

    // Correct stop on target 0x1A in decrementing cycle 5
    step(1'b1, 1'b0, 5'h1A);
    check("a_starting", int'(gif.state_o), 1);
    check("a_target", int'(gif.target_o), 8'h1A);
    idle(7);
    check("a_still_starting", int'(gif.state_o), 1);
    idle(1);
    check("a_dec", int'(gif.state_o), 2);
    check("a_first_count", int'(gif.count_i), 31);
    idle(5);
    check("a_count5", int'(gif.count_i), 8'h1A);
    step(1'b0, 1'b1, 5'($urandom));
    check("a_correct", int'(gif.state_o), 3);
    check("a_score", int'(gif.score_o), 1);
    check("a_en_off", int'(gif.counter_en_o), 0);
    check("a_flash0", int'(gif.flash_o), 0);
    idle(1);
    check("a_flash1", int'(gif.flash_o), 1);
    idle(6);
    check("a_hold_end", int'(gif.state_o), 3);
    step(1'b0, 1'b0, 5'h05);
    check("a_restart", int'(gif.state_o), 1);
    check("a_new_target", int'(gif.target_o), 5);

    // Second correct round reaches WON
    idle(8);
    idle(26);
    check("b_count", int'(gif.count_i), 5);
    step(1'b0, 1'b1, 5'($urandom));
    check("b_score", int'(gif.score_o), 2);
    idle(8);
    check("won_state", int'(gif.state_o), 5);
    check("won_out", int'(gif.won_o), 1);
    check("won_flash0", int'(gif.flash_o), 0);
    idle(1);
    check("won_flash1", int'(gif.flash_o), 1);
    idle(10);
    check("won_stays", int'(gif.state_o), 5);
    step(1'b1, 1'b0, 5'h10);
    check("won_restart", int'(gif.state_o), 1);
    check("won_score_clr", int'(gif.score_o), 0);

    // Wrong stop at 0x11 against target 0x10
    idle(8);
    idle(14);
    check("w_count", int'(gif.count_i), 8'h11);
    step(1'b0, 1'b1, 5'($urandom));
    check("w_wrong", int'(gif.state_o), 4);
    check("w_score", int'(gif.score_o), 0);
    idle(7);
    check("w_hold", int'(gif.state_o), 4);
    idle(1);
    check("w_idle", int'(gif.state_o), 0);

    // Ignored inputs, then target 0 stopped on the zero count
    step(1'b0, 1'b1, 5'($urandom));
    check("ign_stop_idle", int'(gif.state_o), 0);
    step(1'b1, 1'b0, 5'h00);
    step(1'b0, 1'b1, 5'($urandom));
    check("ign_stop_start", int'(gif.state_o), 1);
    idle(7);
    check("z_dec", int'(gif.state_o), 2);
    step(1'b1, 1'b0, 5'h07);
    check("ign_start_dec", int'(gif.target_o), 0);
    idle(30);
    check("z_count0", int'(gif.count_i), 0);
    check("z_still_dec", int'(gif.state_o), 2);
    step(1'b0, 1'b1, 5'($urandom));
    check("z_correct", int'(gif.state_o), 3);
    check("z_score", int'(gif.score_o), 1);

    // Timeout: no stop for a whole round
    idle(8);
    n = 0;
    while (gif.state_o != 3'd2 && n < 20) begin idle(1); n++; end
    n = 0;
    while (gif.state_o == 3'd2 && n < 40) begin idle(1); n++; end
    check("t_dec_len", n, 32);
    check("t_wrong", int'(gif.state_o), 4);
    idle(8);
    check("t_idle", int'(gif.state_o), 0);
    check("t_score_held", int'(gif.score_o), 1);

    // Random play, biased towards stopping on the target
    for (int i = 0; i < 1500; i++) begin
      bit s, p;
      s = ($urandom_range(0, 7) == 0);
      p = ((int'(gif.count_i) == m_target) && ($urandom_range(0, 1) == 1)) ||
          ($urandom_range(0, 15) == 0);
      step(s, p, 5'($urandom));
    end

    // Asynchronous reset in the middle of a round
    n = 0;
    while (gif.state_o != 3'd2 && n < 100) begin step(1'b1, 1'b0, 5'($urandom_range(1, 31))); n++; end
    check("r_reach_dec", int'(gif.state_o), 2);
    idle(3);
    #2 rst = 1'b1;
    #1;
    check("r_async_state", int'(gif.state_o), 0);
    check("r_async_en", int'(gif.counter_en_o), 0);
    check("r_async_score", int'(gif.score_o), 0);
    check("r_async_target", int'(gif.target_o), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("r_hold_state", int'(gif.state_o), 0);
    check("r_hold_target", int'(gif.target_o), 0);
    rst = 1'b0;
    step(1'b1, 1'b0, 5'h09);
    check("r_after", int'(gif.state_o), 1);
    check("r_after_target", int'(gif.target_o), 9);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Sequencing FSM for the Stop-It game, clocked on the 4 Hz game clock. It owns the `game_counter` enable and latches a random target at the start of each round. It judges the player's stop press against the live count and keeps the round score. It sits between the debounced button inputs and the `game_counter` / display logic.

## Interface
Parameters:
- START_DELAY, 8: cycles spent in STARTING before the count runs (≥1)
- RESULT_HOLD, 8: cycles spent in CORRECT or WRONG before advancing (≥1)
- WIN_SCORE, 9: score that ends the game in WON (1..15)

Ports (one clock; reset is asynchronous and active-high):
- clk_4_i  in  1  4 Hz game clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle start pulse, already synchronized and debounced
- stop_i  in  1  one-cycle stop pulse, already synchronized and debounced
- random_i  in  5  free-running random value, sampled as the target
- count_i  in  5  current `game_counter` count
- counter_en_o  out  1  `game_counter` enable
- target_o  out  5  latched target for the current round
- score_o  out  4  consecutive correct rounds
- state_o  out  3  encoded FSM state, for display
- flash_o  out  1  LED flash strobe
- won_o  out  1  high while in WON

## Operation
- States, with encodings: IDLE=0, STARTING=1, DECREMENTING=2, CORRECT=3, WRONG=4, WON=5.
- Reset values: state IDLE, target 0, score 0, timer 0, flash 0. Therefore counter_en_o=0, won_o=0, state_o=0.
- IDLE:
  - start_i → STARTING.
  - On the same edge: target ← random_i, score ← 0, timer ← START_DELAY-1.
- STARTING:
  - The timer decrements each cycle.
  - When the timer is 0 → DECREMENTING.
- DECREMENTING:
  - Only this state drives counter_en_o=1; it is a combinational decode of the state register.
  - stop_i with count_i == target → CORRECT. On the same edge: score ← score+1, timer ← RESULT_HOLD-1.
  - stop_i with count_i != target → WRONG, timer ← RESULT_HOLD-1.
  - No stop_i and count_i == 0 → WRONG, timer ← RESULT_HOLD-1. This prevents counter wrap.
  - stop_i in the same cycle as count_i == 0 is judged as a stop: correct if target == 0.
- CORRECT, when the timer reaches 0:
  - score == WIN_SCORE → WON.
  - Otherwise → STARTING. On the same edge: target ← random_i, timer ← START_DELAY-1.
- WRONG: when the timer reaches 0 → IDLE. Score holds its value until the next start.
- WON:
  - Stays in WON indefinitely.
  - start_i behaves exactly like start_i in IDLE.
- Ignored inputs:
  - start_i is ignored outside IDLE and WON.
  - stop_i is ignored outside DECREMENTING.
- flash_o:
  - Cleared on entry to CORRECT, WRONG or WON.
  - Toggles every cycle while in those states.
  - 0 in every other state.
- Score never exceeds WIN_SCORE, so it cannot overflow.
- An asserted rst_i in any state returns every output to its reset value immediately, without waiting for a clock edge.

## Timing
- All state, target, score and timer updates happen on the rising edge of clk_4_i.
- Outputs are Moore outputs: decoded from registers, with no combinational path from any input.
- STARTING lasts exactly START_DELAY cycles.
- CORRECT and WRONG each last exactly RESULT_HOLD cycles.
- Counter behaviour in DECREMENTING:
  - In the first DECREMENTING cycle, `game_counter` shows 0x1F, because it reloads while its enable is low.
  - In cycle n, counted from 0, count_i = 31-n.
  - A round with no stop times out after 32 DECREMENTING cycles.
- Stop-press latency: stop_i sampled in cycle n is judged against count_i from the same cycle. The verdict state is visible one cycle later.
- counter_en_o drops in the first cycle of the verdict state, so `game_counter` reloads to 0x1F on the following edge.

## Structure
- Shared package `game_pkg` holds:
  - `game_state_e`, a 3-bit enum with the encodings above.
  - Default constants for START_DELAY, RESULT_HOLD and WIN_SCORE.
- Sub-module `game_hold_timer` is one shared instance that serves both STARTING and the result states:
  - loadable down-counter with load_i, load value, and done_o (count == 0);
  - width $clog2(max(START_DELAY, RESULT_HOLD)).
- Expected size: FSM plus datapath of about 150–250 lines.

## Test plan
- Reset:
  - Assert rst_i mid-DECREMENTING with no clock edge → state_o=0, counter_en_o=0, score_o=0 and target_o=0 immediately.
  - Hold rst_i for 3 edges → all outputs stay at those values.
- Correct stop:
  - random_i=0x1A, then start_i.
  - After 8 STARTING cycles, pulse stop_i in DECREMENTING cycle 5 (count_i=0x1A) → CORRECT next edge, score_o=1.
  - After 8 CORRECT cycles → STARTING with a new target.
- Wrong stop:
  - target=0x10; pulse stop_i at count_i=0x11 → WRONG, score unchanged.
  - After 8 cycles → IDLE.
- Timeout and boundaries:
  - No stop → WRONG after count_i=0, which is 32 DECREMENTING cycles; counter_en_o never sees a wrap.
  - target=0 with stop_i at count_i=0 → CORRECT.
- Win:
  - With WIN_SCORE=2, play two correct rounds → WON, won_o=1, flash_o toggling.
  - start_i in WON → STARTING, score_o=0.
- Ignored inputs:
  - stop_i in IDLE or STARTING → no state change.
  - start_i during DECREMENTING → target_o unchanged.
